// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared widths, the "no key" code, FSM state codes and the
// priority encoder used by the key scan encoder.
package key_scan_pkg;

    localparam int KEY_W = 8;
    localparam int IDX_W = 3;

    // All key lines released (active-low).
    localparam logic [KEY_W-1:0] NO_KEY = 8'hFF;

    // FSM state codes.
    typedef logic [0:0] state_t;
    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_HELD = 1'b1;

    // Lowest-index low bit wins; an all-ones vector encodes to 0.
    function automatic logic [IDX_W-1:0] prio_encode(input logic [KEY_W-1:0] keys_n);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (!keys_n[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser followed by a whole-vector debouncer.
// The vector must hold the same value for DEBOUNCE_CYCLES consecutive
// comparisons before it is copied to the stable output; any change in any
// bit restarts the count. All registers reset to all-ones (nothing pressed).
module key_debounce #(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] sync1_p0;
    logic [DATA_W-1:0] sync2_p1;
    logic [DATA_W-1:0] cand_p2;
    logic [CNT_W-1:0]  cnt;

    // Reject parameter sets the counter cannot represent.
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_min
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_chk_cnt
        $error("key_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    // Bring the asynchronous key lines into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_p0 <= '1;
            sync2_p1 <= '1;
        end else begin
            sync1_p0 <= din;
            sync2_p1 <= sync1_p0;
        end
    end

    // Track the candidate vector and accept it once it has stayed put long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_p2 <= '1;
            cnt     <= '0;
            stable  <= '1;
        end else if (sync2_p1 != cand_p2) begin
            // Any bit moved: restart the window on the new value.
            cand_p2 <= sync2_p1;
            cnt     <= '0;
        end else if (cnt == CNT_LAST) begin
            // Counter parks at its last value while the input stays quiet.
            stable <= cand_p2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_scan_encoder.sv
// key_scan_encoder: 8 active-low key lines in, 3-bit key index out with a
// valid/ready handshake. One event per debounced press; a further event
// arriving while the previous one is still unconsumed is dropped and flagged
// with a one-cycle overrun pulse.
// Optional build macro KEY_REPEAT_EN adds auto-repeat while a key is held.
module key_scan_encoder
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] keys_n,
    output logic [IDX_W-1:0] num,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             pressed,
    output logic             overrun
);

    logic [KEY_W-1:0] stable;
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             any_down;
    logic             new_press;
    logic             fire_ev;

    // Repeat timing must be meaningful in every build.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_rep
        $error("key_scan_encoder: repeat delay and period must be positive");
    end

    key_debounce #(
        .DATA_W          (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (keys_n),
        .stable (stable)
    );

    assign idx       = prio_encode(stable);
    assign any_down  = (stable != NO_KEY);
    assign new_press = (state == S_IDLE) && any_down;

`ifdef KEY_REPEAT_EN
    localparam logic [31:0] REP_FIRST_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] REP_NEXT_LAST  = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rep_cnt;
    logic        rep_first;
    logic        rep_fire;

    assign rep_fire = (state == S_HELD) && any_down &&
                      (rep_cnt == (rep_first ? REP_FIRST_LAST : REP_NEXT_LAST));
    assign fire_ev  = new_press || rep_fire;

    // Count cycles spent holding a key; the first interval is the long delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (state != S_HELD || !any_down) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt + 32'd1;
        end
    end
`else
    assign fire_ev = new_press;
`endif

    // Press/release tracking; pressed mirrors the held state as a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pressed <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_down) begin
                        state   <= S_HELD;
                        pressed <= 1'b1;
                    end
                end
                S_HELD: begin
                    // A changed key set while held is ignored; only full release counts.
                    if (!any_down) begin
                        state   <= S_IDLE;
                        pressed <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

    // Output event register: load on a free slot, otherwise flag an overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num       <= '0;
            num_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (fire_ev) begin
                // A consumer accepting in the same cycle frees the slot.
                if (!num_valid || num_ready) begin
                    num       <= idx;
                    num_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (num_valid && num_ready) begin
                num_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_scan_encoder.sv
// tb_key_scan_encoder: directed scenarios followed by randomized key traffic,
// with every output checked each cycle against a behavioural model.
module tb_key_scan_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] keys_n;
    logic [2:0] num;
    logic       num_valid;
    logic       num_ready;
    logic       pressed;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int ovr_seen = 0;
    int m_events = 0;

    // Behavioural model state.
    logic [7:0] hist[$];
    logic [7:0] m_stable;
    logic       m_pressed;
    logic [2:0] m_num;
    logic       m_valid;
    logic       m_overrun;

    always #5 clk = ~clk;

    key_scan_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .REPEAT_DELAY    (1000),
        .REPEAT_PERIOD   (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys_n    (keys_n),
        .num       (num),
        .num_valid (num_valid),
        .num_ready (num_ready),
        .pressed   (pressed),
        .overrun   (overrun)
    );

    function automatic logic [2:0] lowest_zero(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model: a key vector becomes stable once the same
    // value has been sampled D+1 times in a row, two samples back (synchroniser);
    // an event is produced when the stable vector first shows a key down.
    task automatic model_edge(input logic [7:0] k, input logic r, input logic rs);
        logic       ev;
        logic [2:0] ix;
        bit         all_eq;
        int         sz;
        if (!rs) begin
            hist.delete();
            repeat (D + 3) hist.push_back(8'hFF);
            m_stable  = 8'hFF;
            m_pressed = 1'b0;
            m_num     = 3'd0;
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end else begin
            ev = (m_stable != 8'hFF) && !m_pressed;
            ix = lowest_zero(m_stable);
            m_overrun = 1'b0;
            if (ev) begin
                m_events++;
                if (!m_valid || r) begin
                    m_num   = ix;
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
            m_pressed = (m_stable != 8'hFF);
            hist.push_back(k);
            sz = hist.size();
            all_eq = 1'b1;
            for (int j = sz - 3 - D; j <= sz - 3; j++) begin
                if (hist[j] != hist[sz-3]) all_eq = 1'b0;
            end
            if (all_eq) m_stable = hist[sz-3];
            if (hist.size() > 2 * D + 8) void'(hist.pop_front());
        end
    endtask

    task automatic step(input logic [7:0] k, input logic r, input logic rs);
        @(negedge clk);
        keys_n    = k;
        num_ready = r;
        rst_n     = rs;
        @(posedge clk);
        model_edge(k, r, rs);
        #1;
        chk("num",       8'(num),       8'(m_num));
        chk("num_valid", 8'(num_valid), 8'(m_valid));
        chk("pressed",   8'(pressed),   8'(m_pressed));
        chk("overrun",   8'(overrun),   8'(m_overrun));
        if (overrun) ovr_seen++;
    endtask

    task automatic hold(input logic [7:0] k, input logic r, input int n);
        repeat (n) step(k, r, 1'b1);
    endtask

    initial begin
        int base;
        logic [7:0] pat;
        logic [7:0] one;
        int len;
        rst_n     = 1'b0;
        keys_n    = 8'hFF;
        num_ready = 1'b0;

        // Reset held with a key down: all outputs stay low.
        repeat (3) begin
            step(8'hF7, 1'b0, 1'b0);
            chk("rst_num",   8'(num),       8'd0);
            chk("rst_valid", 8'(num_valid), 8'd0);
            chk("rst_press", 8'(pressed),   8'd0);
            chk("rst_ovr",   8'(overrun),   8'd0);
        end
        for (int i = 0; i < 7; i++) begin
            step(8'hF7, 1'b0, 1'b1);
            chk("t1_early_valid", 8'(num_valid), 8'd0);
        end
        step(8'hF7, 1'b0, 1'b1);
        chk("t1_valid", 8'(num_valid), 8'd1);
        chk("t1_num",   8'(num),       8'd3);
        step(8'hFF, 1'b1, 1'b1);
        chk("t1_consume", 8'(num_valid), 8'd0);
        hold(8'hFF, 1'b0, 12);

        // Clean press, held event, one-cycle consume.
        for (int i = 0; i < 7; i++) begin
            step(8'hF7, 1'b0, 1'b1);
            chk("t2_early_valid", 8'(num_valid), 8'd0);
        end
        step(8'hF7, 1'b0, 1'b1);
        chk("t2_valid", 8'(num_valid), 8'd1);
        chk("t2_num",   8'(num),       8'd3);
        hold(8'hF7, 1'b0, 5);
        chk("t2_hold_valid", 8'(num_valid), 8'd1);
        chk("t2_hold_num",   8'(num),       8'd3);
        step(8'hF7, 1'b1, 1'b1);
        chk("t2_consume", 8'(num_valid), 8'd0);
        hold(8'hF7, 1'b0, 4);
        chk("t2_no_second", 8'(num_valid), 8'd0);
        hold(8'hFF, 1'b0, 12);
        chk("t2_release", 8'(pressed), 8'd0);

        // Bounce: 2-cycle runs never settle; one event after the last edge.
        base = ovr_seen;
        for (int i = 0; i < 6; i++) begin
            hold((i % 2 == 0) ? 8'hF7 : 8'hFF, 1'b0, 2);
            chk("t3_bounce_valid", 8'(num_valid), 8'd0);
        end
        for (int i = 0; i < 7; i++) begin
            step(8'hF7, 1'b0, 1'b1);
            chk("t3_wait_valid", 8'(num_valid), 8'd0);
        end
        step(8'hF7, 1'b0, 1'b1);
        chk("t3_valid", 8'(num_valid), 8'd1);
        chk("t3_num",   8'(num),       8'd3);
        chk("t3_ovr",   8'(ovr_seen - base), 8'd0);
        step(8'hF7, 1'b1, 1'b1);
        hold(8'hFF, 1'b0, 12);

        // Multi-key: priority, then a changed set while held gives no event.
        hold(8'h5F, 1'b0, 8);
        chk("t4_num",   8'(num),       8'd5);
        chk("t4_valid", 8'(num_valid), 8'd1);
        step(8'h5F, 1'b1, 1'b1);
        hold(8'h7F, 1'b0, 12);
        chk("t4_no_event", 8'(num_valid), 8'd0);
        chk("t4_pressed",  8'(pressed),   8'd1);
        hold(8'hFF, 1'b0, 12);
        chk("t4_released", 8'(pressed), 8'd0);

        // Overrun: second press while first event is still pending.
        base = ovr_seen;
        hold(8'hFD, 1'b0, 8);
        chk("t5_num", 8'(num), 8'd1);
        hold(8'hFF, 1'b0, 12);
        hold(8'hBF, 1'b0, 12);
        chk("t5_ovr_pulses", 8'(ovr_seen - base), 8'd1);
        chk("t5_num_kept",   8'(num),       8'd1);
        chk("t5_valid_kept", 8'(num_valid), 8'd1);
        hold(8'hFF, 1'b0, 12);

        // Accept and new event in the same cycle.
        for (int i = 0; i < 7; i++) step(8'hEF, 1'b0, 1'b1);
        step(8'hEF, 1'b1, 1'b1);
        chk("t6_num",   8'(num),       8'd4);
        chk("t6_valid", 8'(num_valid), 8'd1);
        chk("t6_ovr",   8'(overrun),   8'd0);

        // Reset mid-operation with the key still held.
        step(8'hEF, 1'b0, 1'b0);
        step(8'hEF, 1'b0, 1'b0);
        chk("rst_mid_valid", 8'(num_valid), 8'd0);
        for (int i = 0; i < 7; i++) begin
            step(8'hEF, 1'b0, 1'b1);
            chk("rst_mid_wait", 8'(num_valid), 8'd0);
        end
        step(8'hEF, 1'b0, 1'b1);
        chk("rst_mid_valid2", 8'(num_valid), 8'd1);
        chk("rst_mid_num",    8'(num),       8'd4);
        hold(8'hFF, 1'b1, 12);

        // Randomized key traffic against the model.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 2)) step(keys_n, 1'b0, 1'b0);
            end
            one = 8'h01 << $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0:       pat = 8'hFF;
                1:       pat = ~one;
                2:       pat = ~(one | (8'h01 << $urandom_range(0, 7)));
                default: pat = 8'($urandom);
            endcase
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                step(pat, ($urandom_range(0, 3) == 0), 1'b1);
            end
        end
        hold(8'hFF, 1'b1, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
